// File: rtl/spi_xfer_seq_if.sv
// Byte handshake between the transaction sequencer and the SPI master engine.
//   master modport : sequencer side (offers TX bytes, receives RX bytes)
//   slave modport  : engine side
// Signals:
//   sp_tx_idle  engine idle
//   sp_tx_dreq  engine can take a byte
//   sp_tx_valid byte offered to the engine
//   sp_tx_data  byte offered to the engine
//   sp_rx_data  received byte
//   sp_rx_valid one-cycle strobe marking sp_rx_data valid
interface spi_xfer_seq_if #(
  parameter int SPI0_0 = 8
);
  logic              sp_tx_idle;
  logic              sp_tx_dreq;
  logic              sp_tx_valid;
  logic [SPI0_0-1:0] sp_tx_data;
  logic [SPI0_0-1:0] sp_rx_data;
  logic              sp_rx_valid;

  modport master (
    input  sp_tx_idle, sp_tx_dreq, sp_rx_data, sp_rx_valid,
    output sp_tx_valid, sp_tx_data
  );

  modport slave (
    output sp_tx_idle, sp_tx_dreq, sp_rx_data, sp_rx_valid,
    input  sp_tx_valid, sp_tx_data
  );
endinterface

// File: rtl/spi_xfer_seq.sv
// SPI transaction sequencer. Accepts a byte-count command, streams TX FIFO
// bytes (or FILL when the FIFO is dry) into the engine, discards a leading
// number of received bytes and buffers the rest in an RX FIFO.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, xfer_len, rx_skip command strobe, byte count, leading RX discard
//   busy, done               not-IDLE flag, one-cycle completion pulse
//   tf_wr_en/_data, tf_full  TX FIFO push side
//   rf_rd_en/_data, rf_empty RX FIFO pop side (first-word fall-through)
//   rf_ovf                   sticky RX overflow flag
//   sp                       engine byte handshake (master modport)

// Synchronous FIFO with first-word fall-through read. A push on a full FIFO
// succeeds when a pop happens in the same cycle; a pop on empty is ignored.
module spi_xfer_seq_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push;
  logic         pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rd_en && !empty;
  assign push    = wr_en && (!full || pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

module spi_xfer_seq #(
  parameter int                SPI0_0  = 8,
  parameter int                LEN_W   = 16,
  parameter int                FIFO_AW = 4,
  parameter logic [SPI0_0-1:0] FILL    = 8'hFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    xfer_len,
  input  logic [LEN_W-1:0]    rx_skip,
  output logic                busy,
  output logic                done,
  input  logic                tf_wr_en,
  input  logic [SPI0_0-1:0]   tf_wr_data,
  output logic                tf_full,
  input  logic                rf_rd_en,
  output logic [SPI0_0-1:0]   rf_rd_data,
  output logic                rf_empty,
  output logic                rf_ovf,
  spi_xfer_seq_if.master      sp
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  skip;
  logic [LEN_W-1:0]  tx_cnt;
  logic [LEN_W-1:0]  rx_cnt;
  logic [SPI0_0-1:0] tf_head;
  logic              tf_empty;
  logic              rf_full;
  logic              xfer;
  logic              rx_take;
  logic              rx_keep;
  logic              rx_drop;

  // FEED always offers a byte, so a transfer is just FEED plus engine ready.
  assign xfer    = (state == FEED) && sp.sp_tx_dreq;
  assign rx_take = ((state == FEED) || (state == DRAIN)) && sp.sp_rx_valid && (rx_cnt < len);
  assign rx_keep = rx_take && (rx_cnt >= skip);
  // The FIFO still accepts a push on full when the host pops in that cycle.
  assign rx_drop = rx_keep && rf_full && !rf_rd_en;

  spi_xfer_seq_fifo #(.W(SPI0_0), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tf_wr_en),
    .wr_data (tf_wr_data),
    .rd_en   (xfer),
    .rd_data (tf_head),
    .full    (tf_full),
    .empty   (tf_empty)
  );

  spi_xfer_seq_fifo #(.W(SPI0_0), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_keep),
    .wr_data (sp.sp_rx_data),
    .rd_en   (rf_rd_en),
    .rd_data (rf_rd_data),
    .full    (rf_full),
    .empty   (rf_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    busy           = (state != IDLE);
    done           = 1'b0;
    sp.sp_tx_valid = 1'b0;
    sp.sp_tx_data  = FILL;
    unique case (state)
      IDLE: begin
        if (start) state_next = (xfer_len != '0) ? FEED : DONE;
      end
      FEED: begin
        sp.sp_tx_valid = 1'b1;
        if (!tf_empty) sp.sp_tx_data = tf_head;
        if (xfer && (tx_cnt == len - LEN_W'(1))) state_next = DRAIN;
      end
      DRAIN: begin
        if ((rx_cnt == len) && sp.sp_tx_idle) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len    <= '0;
      skip   <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      rf_ovf <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        rf_ovf <= 1'b0;
        if (xfer_len != '0) begin
          len    <= xfer_len;
          skip   <= rx_skip;
          tx_cnt <= '0;
          rx_cnt <= '0;
        end
      end
      if (xfer)    tx_cnt <= tx_cnt + LEN_W'(1);
      if (rx_take) rx_cnt <= rx_cnt + LEN_W'(1);
      if (rx_drop) rf_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_xfer_seq.sv
// Self-checking bench for spi_xfer_seq. A loopback engine model returns
// every transferred byte after a configurable latency; a TX queue model
// predicts each engine byte and an RX queue predicts the RX FIFO contents.
module tb_spi_xfer_seq;
  localparam logic [7:0] FILL = 8'hFF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [15:0] xfer_len;
  logic [15:0] rx_skip;
  logic        busy;
  logic        done;
  logic        tf_wr_en;
  logic [7:0]  tf_wr_data;
  logic        tf_full;
  logic        rf_rd_en;
  logic [7:0]  rf_rd_data;
  logic        rf_empty;
  logic        rf_ovf;

  spi_xfer_seq_if #(.SPI0_0(8)) sp_if ();

  spi_xfer_seq #(.SPI0_0(8), .LEN_W(16), .FIFO_AW(4), .FILL(8'hFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .xfer_len   (xfer_len),
    .rx_skip    (rx_skip),
    .busy       (busy),
    .done       (done),
    .tf_wr_en   (tf_wr_en),
    .tf_wr_data (tf_wr_data),
    .tf_full    (tf_full),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_data (rf_rd_data),
    .rf_empty   (rf_empty),
    .rf_ovf     (rf_ovf),
    .sp         (sp_if)
  );

  typedef struct {
    int          len;
    int          skip;
    int          npre;
    logic [31:0] pre;     // preload bytes, byte 0 in bits 7:0
    bit          rnd;     // pseudo-random sp_tx_dreq
    int          lat;     // loopback latency in cycles
    int          idle_x;  // extra quiet cycles before sp_tx_idle rises
    int          kept;    // expected RX FIFO entries
    bit          ovf;     // expected rf_ovf after completion
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] d;
  } rx_ev_t;

  rx_ev_t     pipe[$];
  logic [7:0] tx_model[$];
  logic [7:0] exp_rx[$];
  logic [7:0] seen[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, rx_given, xfer_cnt, valid_cnt, done_cnt, quiet;
  int cur_len, cur_skip, lat_cfg, idle_cfg;
  int flush_gen, flush_seen;
  bit rnd_dreq, exp_ovf;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int len, int skip, int npre, logic [31:0] pre, bit rnd,
                              int lat, int idle_x, int kept, bit ovf);
    vec_t v;
    v.len = len; v.skip = skip; v.npre = npre; v.pre = pre; v.rnd = rnd;
    v.lat = lat; v.idle_x = idle_x; v.kept = kept; v.ovf = ovf;
    return v;
  endfunction

  // Loopback engine: decides dreq, returns delayed RX strobes, and checks
  // every transferred byte against the TX model (FIFO head or FILL).
  task automatic engine();
    sp_if.sp_tx_dreq  = 1'b0;
    sp_if.sp_tx_idle  = 1'b1;
    sp_if.sp_rx_valid = 1'b0;
    sp_if.sp_rx_data  = '0;
    forever begin
      rx_ev_t     ev;
      logic [7:0] e;
      @(negedge clk);
      cyc++;
      if (flush_seen != flush_gen) begin
        flush_seen = flush_gen;
        pipe.delete();
      end
      if (done) begin
        done_cnt++;
        check("done_after_idle", sp_if.sp_tx_idle, 1);
        check("done_after_all_rx", rx_given, cur_len);
      end
      if (sp_if.sp_tx_valid) valid_cnt++;
      sp_if.sp_tx_dreq  = rnd_dreq ? 1'($urandom_range(0, 1)) : 1'b1;
      sp_if.sp_rx_valid = 1'b0;
      if (pipe.size() != 0 && pipe[0].due == cyc) begin
        ev = pipe.pop_front();
        check("rx_ovf_flag", rf_ovf, exp_ovf);
        sp_if.sp_rx_valid = 1'b1;
        sp_if.sp_rx_data  = ev.d;
        if (rx_given >= cur_skip) begin
          if (exp_rx.size() < 16) exp_rx.push_back(ev.d);
          else exp_ovf = 1'b1;
        end
        rx_given++;
      end
      if (sp_if.sp_tx_valid && sp_if.sp_tx_dreq) begin
        if (tx_model.size() != 0) e = tx_model.pop_front();
        else e = FILL;
        check("tx_byte", sp_if.sp_tx_data, e);
        seen.push_back(sp_if.sp_tx_data);
        xfer_cnt++;
        pipe.push_back('{due: cyc + lat_cfg, d: sp_if.sp_tx_data});
      end
      if (pipe.size() == 0) quiet++;
      else quiet = 0;
      sp_if.sp_tx_idle = (quiet > idle_cfg);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    @(negedge clk);
    tf_wr_en   = 1'b1;
    tf_wr_data = d;
    @(posedge clk);
    if (tx_model.size() < 16) tx_model.push_back(d);
    #1 tf_wr_en = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_valid", sp_if.sp_tx_valid, 0);
    check("rst_tx_data", sp_if.sp_tx_data, FILL);
    check("rst_tf_full", tf_full, 0);
    check("rst_rf_empty", rf_empty, 1);
    check("rst_rf_ovf", rf_ovf, 0);
  endtask

  task automatic run_xfer(input vec_t v);
    int w;
    int d0;
    int k;
    for (int i = 0; i < v.npre; i++) push_tx(v.pre[8*i +: 8]);
    rnd_dreq = v.rnd; lat_cfg = v.lat; idle_cfg = v.idle_x;
    cur_len = v.len; cur_skip = v.skip;
    rx_given = 0; xfer_cnt = 0; valid_cnt = 0; exp_ovf = 1'b0;
    seen.delete();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; xfer_len = 16'(v.len); rx_skip = 16'(v.skip);
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_tx_valid", sp_if.sp_tx_valid, 32'(v.len != 0));
    w = 0;
    while (!done && w < 4000) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", done, 1);
    if (v.len == 0) check("zero_len_done_latency", w, 0);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("done_count", done_cnt, d0 + 1);
    check("xfer_count", xfer_cnt, v.len);
    if (v.len == 0) check("zero_len_no_valid", valid_cnt, 0);
    check("rf_ovf_final", rf_ovf, 32'(v.ovf));
    k = 0;
    w = 0;
    while (!rf_empty && w < 64) begin
      if (exp_rx.size() == 0) check("rx_extra_byte", 1, 0);
      else check("rx_data", rf_rd_data, exp_rx.pop_front());
      rf_rd_en = 1'b1;
      k++;
      w++;
      @(negedge clk);
    end
    rf_rd_en = 1'b0;
    check("rx_kept", k, v.kept);
    check("rx_model_drained", exp_rx.size(), 0);
  endtask

  initial begin
    int w;
    int d0;
    int idx;
    rst = 1'b1; start = 1'b0; xfer_len = '0; rx_skip = '0;
    tf_wr_en = 1'b0; tf_wr_data = '0; rf_rd_en = 1'b0;
    cyc = 0; done_cnt = 0; quiet = 0; flush_gen = 0; flush_seen = 0;
    rnd_dreq = 1'b0; lat_cfg = 1; idle_cfg = 0; cur_len = 0; cur_skip = 0;

    //          len skip npre pre           rnd lat idle kept ovf
    vecs[0] = mk(4,  2,   2,  32'h00003CA5, 0,  2,  0,   2,   0);  // basic
    vecs[1] = mk(4,  0,   4,  32'h04030201, 1,  6,  3,   4,   0);  // backpressure
    vecs[2] = mk(3,  5,   0,  32'h0,        0,  1,  0,   0,   0);  // skip > len
    vecs[3] = mk(1,  0,   1,  32'h0000005A, 1,  1,  0,   1,   0);  // single byte
    vecs[4] = mk(6,  6,   2,  32'h00008877, 0,  2,  1,   0,   0);  // skip == len
    vecs[5] = mk(20, 0,   0,  32'h0,        0,  3,  1,   16,  1);  // overflow

    fork
      engine();
    join_none

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // Zero length right after the overflow run also clears the sticky flag.
    run_xfer(mk(0, 0, 0, 32'h0, 0, 1, 0, 0, 0));

    // Streaming: host pushes mid-FEED; a second start during FEED is ignored.
    fork
      run_xfer(mk(8, 0, 0, 32'h0, 0, 2, 0, 8, 0));
      begin
        repeat (4) @(negedge clk);
        push_tx(8'h11);
        push_tx(8'h22);
        @(negedge clk);
        start = 1'b1; xfer_len = 16'd2;
        @(negedge clk);
        start = 1'b0;
      end
    join
    idx = -1;
    for (int i = 0; i < seen.size(); i++) if (idx < 0 && seen[i] == 8'h11) idx = i;
    check("stream_first_fill", seen[0], FILL);
    check("stream_11_seen", 32'(idx >= 1 && idx <= 5), 1);
    if (idx >= 1 && idx <= 5) begin
      check("stream_22_next", seen[idx+1], 8'h22);
      check("stream_fill_after", seen[idx+2], FILL);
    end

    // Full TX FIFO: the 17th push is dropped, so byte 17 is FILL.
    for (int i = 0; i < 16; i++) push_tx(8'(8'h40 + i));
    @(negedge clk);
    check("tf_full_at_16", tf_full, 1);
    push_tx(8'hEE);
    run_xfer(mk(17, 17, 0, 32'h0, 0, 1, 0, 0, 0));
    check("tf_full_after_drain", tf_full, 0);

    // Reset mid-DRAIN: no done, FIFOs emptied, next command runs normally.
    push_tx(8'hC1); push_tx(8'hC2); push_tx(8'hC3);
    rnd_dreq = 1'b0; lat_cfg = 10; idle_cfg = 0;
    cur_len = 2; cur_skip = 0; rx_given = 0; exp_ovf = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; xfer_len = 16'd2; rx_skip = 16'd0;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!(busy && !sp_if.sp_tx_valid) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("reached_drain", 32'(busy && !sp_if.sp_tx_valid), 1);
    rst = 1'b1;
    flush_gen++;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    tx_model.delete();
    exp_rx.delete();
    repeat (10) @(negedge clk);
    check("no_done_after_rst", done_cnt, d0);
    run_xfer(mk(2, 0, 0, 32'h0, 0, 1, 0, 2, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
